jtpopeye_inputs: RTL and testbench

Cabinet input conditioner sitting directly upstream of the main CPU's I/O read decoder. Takes raw, asynchronous, active-low joystick, start, coin and service signals and delivers synchronised, debounced, active-low levels that the CPU samples through its port reads. Coin presses become a fixed-length, frame-counted pulse with lockout, so the game's coin routine counts exactly one credit per insertion.

---
 rtl/jtpopeye_inputs.sv | 173 +++++++++++++++++
 tb/tb_jtpopeye_inputs.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_inputs.sv
// Cabinet input conditioner: 2-FF synchroniser, per-bit debounce and a frame-counted coin pulse.
// Define JTPOPEYE_AUTOFIRE_EN to build in punch autofire for both players.
module jtpopeye_inputs #(
  parameter int DEBOUNCE        = 16,
  parameter int COIN_FRAMES     = 3,
  parameter int AUTOFIRE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       LVBL,
  input  logic [6:0] joystick1,
  input  logic [6:0] joystick2,
  input  logic [1:0] start_button,
  input  logic       coin_input,
  input  logic       service,
  output logic [4:0] joy1_out,
  output logic [4:0] joy2_out,
  output logic [1:0] start_out,
  output logic       coin_out,
  output logic       service_out
);

  localparam int         NB        = 14;
  localparam int         COIN_BIT  = 12;
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE - 1);
  localparam logic [3:0] COIN_LAST = 4'(COIN_FRAMES);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_state_t;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_deb;
  logic [7:0]    r_cnt [NB];
  logic          r_lvbl;
  logic          r_coin_prev;
  logic          w_lvbl_fall;
  logic          w_coin_fall;
  logic          w_coin_n;
  coin_state_t   r_state;
  coin_state_t   w_state_nxt;
  logic [3:0]    r_frames;
  logic [3:0]    w_frames_nxt;
  logic [1:0]    w_punch;
  logic [1:0]    w_punch_out;
  logic          w_unused;

  // Bit map: [4:0] P1, [9:5] P2, [11:10] starts, [12] coin, [13] service
  assign w_raw    = {service, coin_input, start_button, joystick2[4:0], joystick1[4:0]};
  assign w_unused = ^{joystick1[6:5], joystick2[6:5], 4'(AUTOFIRE_FRAMES)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A bit must disagree with its debounced value for DEBOUNCE consecutive ticks to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= '1;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else if (cen) begin
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvbl      <= 1'b1;
      r_coin_prev <= 1'b1;
    end else begin
      r_lvbl      <= LVBL;
      r_coin_prev <= r_deb[COIN_BIT];
    end
  end

  assign w_lvbl_fall = r_lvbl & ~LVBL;
  assign w_coin_fall = r_coin_prev & ~r_deb[COIN_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  // Re-arming only happens through WAIT_REL, so a held or re-bounced coin never double-counts
  always_comb begin
    w_state_nxt  = r_state;
    w_frames_nxt = r_frames;
    w_coin_n     = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_coin_fall) begin
          w_state_nxt  = PULSE;
          w_frames_nxt = '0;
        end
      end
      PULSE: begin
        w_coin_n = 1'b0;
        if (w_lvbl_fall) begin
          w_frames_nxt = r_frames + 4'd1;
          if (w_frames_nxt == COIN_LAST) w_state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (r_deb[COIN_BIT]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_punch = {r_deb[9], r_deb[4]};

`ifdef JTPOPEYE_AUTOFIRE_EN
  localparam logic [3:0] AF_LAST = 4'(AUTOFIRE_FRAMES - 1);

  logic [3:0] r_af_cnt [2];
  logic [1:0] r_af_phase;

  // Phase is zero on the press clock, so the output goes low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af_phase  <= '0;
      r_af_cnt[0] <= '0;
      r_af_cnt[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_punch[p]) begin
          r_af_cnt[p]   <= '0;
          r_af_phase[p] <= 1'b0;
        end else if (w_lvbl_fall) begin
          if (r_af_cnt[p] == AF_LAST) begin
            r_af_cnt[p]   <= '0;
            r_af_phase[p] <= ~r_af_phase[p];
          end else begin
            r_af_cnt[p] <= r_af_cnt[p] + 4'd1;
          end
        end
      end
    end
  end

  assign w_punch_out = w_punch | r_af_phase;
`else
  assign w_punch_out = w_punch;
`endif

  assign joy1_out    = {w_punch_out[0], r_deb[3:0]};
  assign joy2_out    = {w_punch_out[1], r_deb[8:5]};
  assign start_out   = r_deb[11:10];
  assign coin_out    = w_coin_n;
  assign service_out = r_deb[13];

endmodule

// File: tb/tb_jtpopeye_inputs.sv
// Randomised bench for jtpopeye_inputs with a window-based debounce and event-based coin model.
module tb_jtpopeye_inputs;
  localparam int DEB   = 16;
  localparam int CF    = 3;
  localparam int AF    = 4;
  localparam int FRAME = 120;
  localparam int VB    = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       LVBL = 1'b1;
  logic [6:0] joystick1, joystick2;
  logic [1:0] start_button;
  logic       coin_input, service;
  logic [4:0] joy1_out, joy2_out;
  logic [1:0] start_out;
  logic       coin_out, service_out;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   lvbl_auto = 1'b1;
  int   cen_mode = 0;
  logic [13:0] raw_drv = '1;

  // Reference model state
  logic [13:0] raw_q[$];
  logic [13:0] tick_q[$];
  logic [13:0] m_deb, m_deb_prev;
  logic        m_lvbl_prev, m_coin_low, m_coin_locked;
  int          m_coin_frames;
  int          m_af_falls[2];

  jtpopeye_inputs #(.DEBOUNCE(DEB), .COIN_FRAMES(CF), .AUTOFIRE_FRAMES(AF)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL),
    .joystick1(joystick1), .joystick2(joystick2), .start_button(start_button),
    .coin_input(coin_input), .service(service),
    .joy1_out(joy1_out), .joy2_out(joy2_out), .start_out(start_out),
    .coin_out(coin_out), .service_out(service_out)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] dut_vec();
    return {service_out, coin_out, start_out, joy2_out, joy1_out};
  endfunction

  function automatic logic [13:0] m_exp();
    logic [13:0] e;
    e = m_deb;
    e[12] = ~m_coin_low;
`ifdef JTPOPEYE_AUTOFIRE_EN
    e[4] = m_deb[4] | (((m_af_falls[0] / AF) % 2) != 0);
    e[9] = m_deb[9] | (((m_af_falls[1] / AF) % 2) != 0);
`endif
    return e;
  endfunction

  task automatic m_reset();
    raw_q.delete();
    tick_q.delete();
    m_deb = '1;
    m_deb_prev = '1;
    m_lvbl_prev = 1'b1;
    m_coin_low = 1'b0;
    m_coin_locked = 1'b0;
    m_coin_frames = 0;
    m_af_falls[0] = 0;
    m_af_falls[1] = 0;
  endtask

  // Applied at each rising edge with the inputs that were present before it
  task automatic model_edge();
    logic [13:0] syn, nd;
    logic        lv_fall, coin_fall, all_diff;
    if (!rst_n) begin
      m_reset();
    end else begin
      syn = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 14'h3fff;
      raw_q.push_back({service, coin_input, start_button, joystick2[4:0], joystick1[4:0]});
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      nd = m_deb;
      if (cen) begin
        tick_q.push_back(syn);
        if (tick_q.size() > DEB) void'(tick_q.pop_front());
        if (tick_q.size() == DEB) begin
          for (int b = 0; b < 14; b++) begin
            all_diff = 1'b1;
            foreach (tick_q[i]) if (tick_q[i][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
          end
        end
      end
      lv_fall   = m_lvbl_prev & ~LVBL;
      coin_fall = m_deb_prev[12] & ~m_deb[12];
      if (m_coin_low) begin
        if (lv_fall) begin
          m_coin_frames++;
          if (m_coin_frames == CF) begin
            m_coin_low = 1'b0;
            m_coin_locked = 1'b1;
          end
        end
      end else if (m_coin_locked) begin
        if (m_deb[12]) m_coin_locked = 1'b0;
      end else if (coin_fall) begin
        m_coin_low = 1'b1;
        m_coin_frames = 0;
      end
      if (m_deb[4]) m_af_falls[0] = 0; else if (lv_fall) m_af_falls[0]++;
      if (m_deb[9]) m_af_falls[1] = 0; else if (lv_fall) m_af_falls[1]++;
      m_lvbl_prev = LVBL;
      m_deb_prev = m_deb;
      m_deb = nd;
    end
  endtask

  task automatic apply_raw();
    joystick1    = {2'($urandom_range(0, 3)), raw_drv[4:0]};
    joystick2    = {2'($urandom_range(0, 3)), raw_drv[9:5]};
    start_button = raw_drv[11:10];
    coin_input   = raw_drv[12];
    service      = raw_drv[13];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (lvbl_auto) LVBL = (cyc % FRAME) < (FRAME - VB);
    if (cen_mode == 0) cen = (cyc % 4) == 0;
    else cen = ($urandom_range(0, 2) == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_drv = '0;
    apply_raw();
    cen_mode = 0;
    m_reset();
    repeat (5) step();
    checks++;
    if (dut_vec() !== 14'h3fff) begin
      errors++; $display("FAIL reset_hold got=%h want=3fff", dut_vec());
    end
    rst_n = 1'b1;
    repeat (4 * (DEB + 4)) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
    end
    checks++;
    if ({service_out, start_out, joy2_out, joy1_out} !== 13'h0) begin
      errors++; $display("FAIL reset_release_low got=%h want=0", {service_out, start_out, joy2_out, joy1_out});
    end
    raw_drv = '1;
    apply_raw();
    repeat (4 * FRAME) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL reset_restore cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
    end
  endtask

  task automatic test_bounce();
    cen_mode = 0;
    for (int r = 0; r < 5; r++) begin
      raw_drv[3] = 1'b0;
      apply_raw();
      repeat (4 * (DEB - 2)) begin
        step();
        checks++;
        if (dut_vec() !== m_exp() || joy1_out[3] !== 1'b1) begin
          errors++; $display("FAIL bounce_short cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
        end
      end
      raw_drv[3] = 1'b1;
      apply_raw();
      repeat (16) begin
        step();
        checks++;
        if (dut_vec() !== m_exp() || joy1_out[3] !== 1'b1) begin
          errors++; $display("FAIL bounce_gap cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
        end
      end
    end
    raw_drv[3] = 1'b0;
    apply_raw();
    repeat (4 * 20 + 4) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL bounce_hold cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
    end
    checks++;
    if (joy1_out[3] !== 1'b0) begin
      errors++; $display("FAIL bounce_accept got=%b want=0", joy1_out[3]);
    end
    raw_drv[3] = 1'b1;
    apply_raw();
    repeat (4 * (DEB + 4)) step();
    checks++;
    if (joy1_out[3] !== 1'b1) begin
      errors++; $display("FAIL bounce_release got=%b want=1", joy1_out[3]);
    end
  endtask

  task automatic test_coin();
    int pulses, lowlen;
    logic prev;
    cen_mode = 0;
    lvbl_auto = 1'b1;
    pulses = 0; lowlen = 0; prev = coin_out;
    raw_drv[12] = 1'b0;
    apply_raw();
    repeat (10 * FRAME) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL coin_hold cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
      if (prev && !coin_out) pulses++;
      if (!coin_out) lowlen++;
      prev = coin_out;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL coin_pulse_count got=%0d want=1", pulses);
    end
    checks++;
    if (lowlen <= (CF - 1) * FRAME || lowlen > CF * FRAME) begin
      errors++; $display("FAIL coin_low_time got=%0d want=%0d..%0d", lowlen, (CF - 1) * FRAME + 1, CF * FRAME);
    end
    raw_drv[12] = 1'b1;
    apply_raw();
    repeat (4 * (DEB + 4)) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL coin_release cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
    end
    pulses = 0; prev = coin_out;
    raw_drv[12] = 1'b0;
    apply_raw();
    repeat (5 * FRAME) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL coin_repress cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
      if (prev && !coin_out) pulses++;
      prev = coin_out;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL coin_repress_count got=%0d want=1", pulses);
    end
    raw_drv[12] = 1'b1;
    apply_raw();
    repeat (4 * (DEB + 4)) step();
  endtask

  task automatic test_reset_pulse();
    int pulses, guard;
    logic prev;
    cen_mode = 0;
    raw_drv[12] = 1'b0;
    apply_raw();
    guard = 0;
    while (coin_out !== 1'b0 && guard < 400) begin step(); guard++; end
    checks++;
    if (guard >= 400) begin
      errors++; $display("FAIL rstpulse_start timeout got=%b want=0", coin_out);
    end
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (dut_vec() !== 14'h3fff) begin
      errors++; $display("FAIL rstpulse_async got=%h want=3fff", dut_vec());
    end
    repeat (3) step();
    rst_n = 1'b1;
    pulses = 0; prev = coin_out;
    repeat (6 * FRAME) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL rstpulse_after cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
      if (prev && !coin_out) pulses++;
      prev = coin_out;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL rstpulse_count got=%0d want=1", pulses);
    end
    raw_drv[12] = 1'b1;
    apply_raw();
    repeat (4 * (DEB + 4)) step();
  endtask

  task automatic test_release_edge();
    int pulses, guard;
    logic prev;
    cen_mode = 0;
    lvbl_auto = 1'b0;
    LVBL = 1'b1;
    repeat (4) step();
    pulses = 0; prev = coin_out;
    raw_drv[12] = 1'b0;
    apply_raw();
    guard = 0;
    while (coin_out !== 1'b0 && guard < 400) begin
      step(); guard++;
      if (prev && !coin_out) pulses++;
      prev = coin_out;
    end
    raw_drv[12] = 1'b1;
    apply_raw();
    guard = 0;
    while (m_deb[12] !== 1'b1 && guard < 400) begin step(); guard++; end
    checks++;
    if (dut_vec() !== m_exp() || coin_out !== 1'b0) begin
      errors++; $display("FAIL reledge_pre got=%h want=%h", dut_vec(), m_exp());
    end
    LVBL = 1'b0;
    step();
    checks++;
    if (coin_out !== ((CF == 1) ? 1'b1 : 1'b0)) begin
      errors++; $display("FAIL reledge_first_frame got=%b want=%b", coin_out, (CF == 1));
    end
    for (int k = 1; k < CF; k++) begin
      LVBL = 1'b1;
      repeat (3) step();
      LVBL = 1'b0;
      repeat (3) step();
    end
    checks++;
    if (dut_vec() !== m_exp() || coin_out !== 1'b1) begin
      errors++; $display("FAIL reledge_end got=%h want=%h", dut_vec(), m_exp());
    end
    lvbl_auto = 1'b1;
    prev = coin_out;
    repeat (2 * FRAME) begin
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL reledge_after cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
      if (prev && !coin_out) pulses++;
      prev = coin_out;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL reledge_count got=%0d want=1", pulses);
    end
  endtask

  task automatic test_autofire();
    int toggles, guard, want;
    logic prev;
    cen_mode = 0;
    lvbl_auto = 1'b1;
    raw_drv[9] = 1'b0;
    apply_raw();
    guard = 0;
    while (m_deb[9] !== 1'b0 && guard < 400) begin step(); guard++; end
    checks++;
    if (joy2_out[4] !== 1'b0) begin
      errors++; $display("FAIL autofire_start got=%b want=0", joy2_out[4]);
    end
    toggles = 0; prev = joy2_out[4]; guard = 0;
    while (m_af_falls[1] < 16 && guard < 20 * FRAME) begin
      step(); guard++;
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL autofire_hold cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
      if (joy2_out[4] !== prev) toggles++;
      prev = joy2_out[4];
    end
`ifdef JTPOPEYE_AUTOFIRE_EN
    want = 16 / AF;
`else
    want = 0;
`endif
    checks++;
    if (toggles !== want) begin
      errors++; $display("FAIL autofire_toggles got=%0d want=%0d", toggles, want);
    end
    raw_drv[9] = 1'b1;
    apply_raw();
    repeat (4 * (DEB + 4)) step();
    checks++;
    if (joy2_out[4] !== 1'b1) begin
      errors++; $display("FAIL autofire_release got=%b want=1", joy2_out[4]);
    end
  endtask

  task automatic test_random();
    cen_mode = 1;
    lvbl_auto = 1'b1;
    repeat (6000) begin
      if ($urandom_range(0, 29) == 0) begin
        int b;
        b = int'($urandom_range(0, 13));
        raw_drv[b] = ~raw_drv[b];
      end
      apply_raw();
      step();
      checks++;
      if (dut_vec() !== m_exp()) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec(), m_exp());
      end
    end
  endtask

  initial begin
    raw_drv = '1;
    apply_raw();
    test_reset();
    test_bounce();
    test_coin();
    test_reset_pulse();
    test_release_edge();
    test_autofire();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
